cnt_share_ctrl: RTL and testbench

Controller that shares one CW-bit up-counter (the existing `cnt` datapath) between NREQ requesters. Arbitrates round-robin, then sequences the granted burst: clears the counter, enables counting up to LAST, and signals completion. Sits between the requesting blocks and the counter instance. It drives the counter's clear/enable and only reads back its value.

---
 rtl/cnt_share_pkg.sv | 20 ++
 rtl/cnt_share_ctrl_if.sv | 25 ++
 rtl/cnt_share_ctrl_rr_pick.sv | 37 +++
 rtl/cnt_share_ctrl.sv | 104 ++++++++++
 tb/tb_cnt_share_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnt_share_pkg.sv
// Shared definitions for the counter-sharing controller: FSM encoding and
// width helpers used by the controller and its round-robin picker.
package cnt_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Widest request vector the controller supports.
  typedef logic [7:0] onehot_t;

  // Index width for an n-entry one-hot vector; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnt_share_ctrl_if.sv
// Bundle between the requesters/counter (master side) and the controller
// (slave side) that arbitrates them onto the shared counter.
interface cnt_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0] req;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic            cnt_clr;
  logic            cnt_en;
  logic [NREQ-1:0] done;
  logic            abort;
  logic            busy;

  modport master (
    output req, cnt,
    input  gnt, cnt_clr, cnt_en, done, abort, busy
  );

  modport slave (
    input  req, cnt,
    output gnt, cnt_clr, cnt_en, done, abort, busy
  );
endinterface

// File: rtl/cnt_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap. Returns the one-hot pick and its index.
module rr_pick
  import cnt_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic [PW-1:0]   idx_o
);

  int          j;
  logic [PW-1:0] j_w;
  logic        found;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    j      = 0;
    j_w    = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      j_w = PW'(j);
      if (!found && req_i[j_w]) begin
        found       = 1'b1;
        pick_o[j_w] = 1'b1;
        idx_o       = j_w;
      end
    end
  end

endmodule

// File: rtl/cnt_share_ctrl.sv
// Shares one up-counter between NREQ requesters: round-robin grant, then
// clear / count to LAST / finish, with abort when the granted request drops.
module cnt_share_ctrl
  import cnt_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = 4,
  parameter int LAST = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  cnt_share_ctrl_if.slave  bus
);

  localparam int PW = idx_w(NREQ);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_CLR  = 2'(ST_CLR);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);
  localparam logic [1:0] S_FIN  = 2'(ST_FIN);

  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [PW-1:0]   ptr_q,   ptr_d;
  logic [PW-1:0]   gidx_q,  gidx_d;
  logic            abort_q, abort_d;

  logic [NREQ-1:0] pick;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   ptr_next;
  logic            gnt_req;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

  assign ptr_next = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
  assign gnt_req  = |(bus.req & gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (|bus.req) begin
          gnt_d   = pick;
          gidx_d  = pick_idx;
          state_d = S_CLR;
        end
      end
      S_CLR: state_d = S_RUN;
      S_RUN: begin
        // A withdrawn request ends the burst even on the terminal count.
        if (!gnt_req) begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end else if (bus.cnt == LAST_C) begin
          abort_d = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        gnt_d   = '0;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      abort_q <= abort_d;
    end
  end

  // Everything but cnt_en is a function of registered state only.
  assign bus.gnt     = gnt_q;
  assign bus.cnt_clr = (state_q == S_CLR);
  assign bus.cnt_en  = (state_q == S_RUN) && (bus.cnt != LAST_C);
  assign bus.done    = (state_q == S_FIN) ? gnt_q : '0;
  assign bus.abort   = (state_q == S_FIN) && abort_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_cnt_share_ctrl.sv
// Self-checking bench for cnt_share_ctrl with a behavioural counter and a
// round-robin reference model tracking the expected search pointer.
module tb_cnt_share_ctrl;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int LAST = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_ptr = 0;

  cnt_share_ctrl_if #(.NREQ(NREQ), .CW(CW)) bus ();

  cnt_share_ctrl #(.NREQ(NREQ), .CW(CW), .LAST(LAST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared counter datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          bus.cnt <= '0;
    else if (bus.cnt_clr)  bus.cnt <= '0;
    else if (bus.cnt_en)   bus.cnt <= bus.cnt + 1'b1;
  end

  typedef struct {
    logic [NREQ-1:0] g;
    logic            clr;
    int              wait_cyc;
    int              runs;
    bit              seq_ok;
    bit              stable;
    int              en_cycles;
    int              len;
    logic [NREQ-1:0] done;
    logic            abort;
    bit              en_after;
    bit              idle_ok;
    bit              timeout;
  } obs_t;

  function automatic int exp_pick(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] t;
    for (int k = 0; k < NREQ; k++) begin
      t = r >> ((p + k) % NREQ);
      if (t[0]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    return NREQ'(1) << idx;
  endfunction

  // Runs one burst from IDLE. drop_at >= 0 withdraws the granted request in
  // the RUN cycle showing that count; -2 withdraws it during CLR.
  task automatic do_burst(input logic [NREQ-1:0] rv, input int drop_at,
                          input bit keep, output obs_t o);
    int guard;
    o = '{default: '0};
    o.seq_ok = 1'b1;
    o.stable = 1'b1;
    bus.req  = rv;
    guard    = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (bus.gnt == '0 && guard < 5);
    o.wait_cyc = guard;
    if (bus.gnt == '0) begin o.timeout = 1'b1; return; end
    o.g   = bus.gnt;
    o.clr = bus.cnt_clr;
    o.len = 1;
    if (drop_at == -2) bus.req = bus.req & ~o.g;
    guard = 0;
    @(negedge clk);
    while (bus.done == '0 && guard < 4 * LAST + 20) begin
      guard++;
      o.len++;
      if (bus.cnt !== CW'(o.runs)) o.seq_ok = 1'b0;
      if (bus.gnt !== o.g) o.stable = 1'b0;
      if (bus.cnt_en) o.en_cycles++;
      if (drop_at >= 0 && bus.cnt == CW'(drop_at)) bus.req = bus.req & ~o.g;
      o.runs++;
      @(negedge clk);
    end
    if (bus.done == '0) begin o.timeout = 1'b1; return; end
    o.len++;
    if (bus.gnt !== o.g) o.stable = 1'b0;
    o.done     = bus.done;
    o.abort    = bus.abort;
    o.en_after = bus.cnt_en;
    if (!keep) bus.req = '0;
    @(negedge clk);
    o.idle_ok  = (bus.busy == 1'b0) && (bus.gnt == '0) && (bus.done == '0) && (bus.abort == 1'b0);
    o.en_after = o.en_after | bus.cnt_en;
  endtask

  task automatic test_reset();
    obs_t o;
    int   idx;
    reset_n = 1'b0;
    bus.req = '1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if ({bus.cnt_clr, bus.cnt_en, bus.abort, bus.done} !== '0) begin n_fail++;
      $display("FAIL reset_outs: clr=%b en=%b abort=%b done=%b want all 0", bus.cnt_clr, bus.cnt_en, bus.abort, bus.done); end
    reset_n   = 1'b1;
    model_ptr = 0;
    idx = exp_pick(4'b1111, model_ptr);
    do_burst(4'b1111, -2, 1'b0, o);
    n_checks++; if (o.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_release_timeout: got %b want 0", o.timeout); end
    n_checks++; if (o.wait_cyc !== 1) begin n_fail++; $display("FAIL reset_release_latency: got %0d want 1", o.wait_cyc); end
    n_checks++; if (o.g !== onehot(idx)) begin n_fail++; $display("FAIL reset_release_gnt: got %b want %b", o.g, onehot(idx)); end
    n_checks++; if (o.clr !== 1'b1) begin n_fail++; $display("FAIL reset_release_clr: got %b want 1", o.clr); end
    n_checks++; if (o.runs !== 1) begin n_fail++; $display("FAIL clr_drop_runs: got %0d want 1", o.runs); end
    n_checks++; if (o.abort !== 1'b1 || o.done !== onehot(idx)) begin n_fail++;
      $display("FAIL clr_drop_done: done=%b abort=%b want %b/1", o.done, o.abort, onehot(idx)); end
    model_ptr = (idx + 1) % NREQ;
  endtask

  task automatic test_single_burst();
    obs_t o;
    int   idx;
    idx = exp_pick(4'b0100, model_ptr);
    do_burst(4'b0100, -1, 1'b0, o);
    n_checks++; if (o.timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", o.timeout); end
    n_checks++; if (o.g !== onehot(idx)) begin n_fail++; $display("FAIL single_gnt: got %b want %b", o.g, onehot(idx)); end
    n_checks++; if (o.runs !== LAST + 1) begin n_fail++; $display("FAIL single_runs: got %0d want %0d", o.runs, LAST + 1); end
    n_checks++; if (o.seq_ok !== 1'b1) begin n_fail++; $display("FAIL single_cnt_seq: got %b want 1", o.seq_ok); end
    n_checks++; if (o.en_cycles !== LAST) begin n_fail++; $display("FAIL single_en_cycles: got %0d want %0d", o.en_cycles, LAST); end
    n_checks++; if (o.stable !== 1'b1 || o.len !== LAST + 3) begin n_fail++;
      $display("FAIL single_gnt_hold: stable=%b len=%0d want 1/%0d", o.stable, o.len, LAST + 3); end
    n_checks++; if (o.done !== onehot(idx) || o.abort !== 1'b0) begin n_fail++;
      $display("FAIL single_done: done=%b abort=%b want %b/0", o.done, o.abort, onehot(idx)); end
    n_checks++; if (o.idle_ok !== 1'b1) begin n_fail++; $display("FAIL single_idle_after: got %b want 1", o.idle_ok); end
    model_ptr = (idx + 1) % NREQ;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int   idx;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
    model_ptr = 0;
    for (int k = 0; k < 5; k++) begin
      idx = exp_pick(4'b1111, model_ptr);
      do_burst(4'b1111, -1, (k < 4), o);
      n_checks++; if (o.g !== onehot(idx) || o.wait_cyc !== 1) begin n_fail++;
        $display("FAIL rr_gnt_%0d: got %b after %0d want %b after 1", k, o.g, o.wait_cyc, onehot(idx)); end
      n_checks++; if (o.done !== onehot(idx) || o.abort !== 1'b0) begin n_fail++;
        $display("FAIL rr_done_%0d: done=%b abort=%b want %b/0", k, o.done, o.abort, onehot(idx)); end
      n_checks++; if (o.idle_ok !== 1'b1) begin n_fail++; $display("FAIL rr_idle_gap_%0d: got %b want 1", k, o.idle_ok); end
      model_ptr = (idx + 1) % NREQ;
    end
  endtask

  task automatic test_abort();
    obs_t o;
    int   idx;
    idx = exp_pick(4'b0010, model_ptr);
    do_burst(4'b0010, 3, 1'b0, o);
    n_checks++; if (o.g !== onehot(idx)) begin n_fail++; $display("FAIL abort_gnt: got %b want %b", o.g, onehot(idx)); end
    n_checks++; if (o.runs !== 4) begin n_fail++; $display("FAIL abort_runs: got %0d want 4", o.runs); end
    n_checks++; if (o.done !== onehot(idx) || o.abort !== 1'b1) begin n_fail++;
      $display("FAIL abort_done: done=%b abort=%b want %b/1", o.done, o.abort, onehot(idx)); end
    n_checks++; if (o.en_after !== 1'b0) begin n_fail++; $display("FAIL abort_en_after: got %b want 0", o.en_after); end
    n_checks++; if (o.idle_ok !== 1'b1) begin n_fail++; $display("FAIL abort_idle_after: got %b want 1", o.idle_ok); end
    model_ptr = (idx + 1) % NREQ;
  endtask

  task automatic test_async_reset();
    obs_t o;
    int   idx;
    int   guard;
    idx     = exp_pick(4'b0010, model_ptr);
    bus.req = 4'b0010;
    guard   = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(bus.busy && !bus.cnt_clr && bus.cnt == CW'(5)) && guard < 30);
    n_checks++; if (bus.cnt !== CW'(5) || bus.gnt !== onehot(idx)) begin n_fail++;
      $display("FAIL areset_reach_cnt5: cnt=%0d gnt=%b want 5/%b", bus.cnt, bus.gnt, onehot(idx)); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.gnt !== '0 || bus.cnt_en !== 1'b0 || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL areset_immediate: gnt=%b en=%b busy=%b want 0/0/0", bus.gnt, bus.cnt_en, bus.busy); end
    n_checks++; if (bus.done !== '0 || bus.abort !== 1'b0) begin n_fail++;
      $display("FAIL areset_no_done: done=%b abort=%b want 0/0", bus.done, bus.abort); end
    bus.req = 4'b1000;
    @(negedge clk);
    n_checks++; if (bus.done !== '0) begin n_fail++; $display("FAIL areset_hold_done: got %b want 0", bus.done); end
    reset_n   = 1'b1;
    model_ptr = 0;
    idx = exp_pick(4'b1000, model_ptr);
    do_burst(4'b1000, -1, 1'b0, o);
    n_checks++; if (o.g !== onehot(idx) || o.wait_cyc !== 1) begin n_fail++;
      $display("FAIL areset_regrant: got %b after %0d want %b after 1", o.g, o.wait_cyc, onehot(idx)); end
    n_checks++; if (o.done !== onehot(idx) || o.abort !== 1'b0 || o.runs !== LAST + 1) begin n_fail++;
      $display("FAIL areset_burst: done=%b abort=%b runs=%0d want %b/0/%0d", o.done, o.abort, o.runs, onehot(idx), LAST + 1); end
    model_ptr = (idx + 1) % NREQ;
  endtask

  task automatic test_wrap();
    obs_t o;
    int   idx;
    idx = exp_pick(4'b0100, model_ptr);
    do_burst(4'b0100, -1, 1'b0, o);
    n_checks++; if (o.g !== onehot(idx)) begin n_fail++; $display("FAIL wrap_setup_gnt: got %b want %b", o.g, onehot(idx)); end
    model_ptr = (idx + 1) % NREQ;
    idx = exp_pick(4'b0011, model_ptr);
    do_burst(4'b0011, -1, 1'b0, o);
    n_checks++; if (o.g !== onehot(idx) || o.done !== onehot(idx)) begin n_fail++;
      $display("FAIL wrap_gnt: gnt=%b done=%b want %b", o.g, o.done, onehot(idx)); end
    model_ptr = (idx + 1) % NREQ;
  endtask

  task automatic test_random();
    obs_t            o;
    int              idx;
    int              drop;
    logic [NREQ-1:0] rv;
    for (int it = 0; it < 40; it++) begin
      rv   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, LAST)) : -1;
      idx  = exp_pick(rv, model_ptr);
      do_burst(rv, drop, 1'b0, o);
      n_checks++; if (o.timeout !== 1'b0 || o.g !== onehot(idx)) begin n_fail++;
        $display("FAIL rand_gnt_%0d: req=%b gnt=%b timeout=%b want %b", it, rv, o.g, o.timeout, onehot(idx)); end
      n_checks++; if (o.done !== onehot(idx) || o.abort !== (drop >= 0)) begin n_fail++;
        $display("FAIL rand_done_%0d: done=%b abort=%b want %b/%0d", it, o.done, o.abort, onehot(idx), drop >= 0); end
      n_checks++; if (o.runs !== ((drop >= 0) ? drop + 1 : LAST + 1) || o.seq_ok !== 1'b1) begin n_fail++;
        $display("FAIL rand_runs_%0d: runs=%0d seq=%b drop=%0d", it, o.runs, o.seq_ok, drop); end
      model_ptr = (idx + 1) % NREQ;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_abort();
    test_async_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
